// File: rtl/uart_rx_frame.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Delivers bytes through a one-deep valid/ready holding register and flags
// framing, parity and overrun errors as single-cycle pulses.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s to fall
// S_START  | confirming the start bit at its midpoint (glitch filter)
// S_DATA   | sampling 8 data bits mid-bit, LSB first
// S_PARITY | sampling the even-parity bit (PARITY_EN only)
// S_STOP   | sampling the stop bit; deliver byte or flag framing error
// S_BREAK  | line held low after a bad stop bit; wait for it to go high
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_flag_q, par_flag_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err_q, parity_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_s;
  logic            cnt_tc;

  assign rx_s = sync_q[1];

  // State, synchroniser, counters and output register flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      par_flag_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      par_flag_q   <= par_flag_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state, bit sampling, delivery/handshake and baud counter
  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[0], rx_pin};
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    par_flag_d   = par_flag_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    cnt_tc       = (cnt_q == CNT_LAST);

    if (valid_q && m_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          idx_d      = '0;
          par_flag_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_MID) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_tc) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt_tc) begin
          par_flag_d = (^shreg_q) ^ rx_s;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_tc) begin
          if (rx_s) begin
            state_d      = S_IDLE;
            parity_err_d = par_flag_q;
            // A byte consumed this same cycle frees the register for the new one
            if (valid_q && !m_ready) begin
              overrun_d = 1'b1;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Restart on every state entry and at the end of each bit period
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_BREAK) || cnt_tc)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  assign m_data     = data_q;
  assign m_valid    = valid_q;
  assign rx_busy    = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: one instance without parity, one with parity.
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1;
  logic       rdy0, rdy1;
  logic [7:0] d0, d1;
  logic       v0, v1, busy0, busy1, fe0, fe1, pe0, pe1, ov0, ov1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] got0[$], got1[$];
  int         gotc0[$];
  int vh0 = 0, fe_n0 = 0, pe_n0 = 0, ov_n0 = 0, busy_n0 = 0;
  int fe_n1 = 0, pe_n1 = 0, ov_n1 = 0, pev_n1 = 0;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx0), .m_data(d0), .m_valid(v0), .m_ready(rdy0),
    .rx_busy(busy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst), .rx_pin(rx1), .m_data(d1), .m_valid(v1), .m_ready(rdy1),
    .rx_busy(busy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample on the falling edge, record accepted bytes and pulses
  always @(negedge clk) begin
    if (rst) begin
      if (v0 && rdy0) begin got0.push_back(d0); gotc0.push_back(cyc); end
      if (v1 && rdy1) got1.push_back(d1);
      if (v0) vh0++;
      if (fe0) fe_n0++;
      if (pe0) pe_n0++;
      if (ov0) ov_n0++;
      if (busy0) busy_n0++;
      if (fe1) fe_n1++;
      if (pe1) pe_n1++;
      if (ov1) ov_n1++;
      if (pe1 && v1) pev_n1++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic val);
    if (which == 0) rx0 = val; else rx1 = val;
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input bit with_par,
                            input logic par_bit, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    set_line(which, 1'b0);
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      wait_cyc(CPB);
    end
    if (with_par) begin
      set_line(which, par_bit);
      wait_cyc(CPB);
    end
    set_line(which, stop_bit);
    wait_cyc(CPB);
    set_line(which, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    wait_cyc(3);
    checks++;
    if ({d0, v0, busy0, fe0, pe0, ov0} !== 13'd0) begin
      errors++; $display("FAIL reset_dut0: got %b expected all zero", {d0, v0, busy0, fe0, pe0, ov0});
    end
    checks++;
    if ({d1, v1, busy1, fe1, pe1, ov1} !== 13'd0) begin
      errors++; $display("FAIL reset_dut_p: got %b expected all zero", {d1, v1, busy1, fe1, pe1, ov1});
    end
    rst = 1'b1;
    wait_cyc(5);
    checks++;
    if ({v0, busy0, v1, busy1} !== 4'd0) begin
      errors++; $display("FAIL reset_idle: got %b expected 0000", {v0, busy0, v1, busy1});
    end
  endtask

  task automatic test_single;
    int base, vb, fb, pb, ob, st, lat;
    base = got0.size(); vb = vh0; fb = fe_n0; pb = pe_n0; ob = ov_n0;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, st);
    wait_cyc(2 * CPB);
    checks++;
    if (got0.size() - base !== 1) begin
      errors++; $display("FAIL single_count: got %0d bytes expected 1", got0.size() - base);
    end else begin
      checks++;
      if (got0[base] !== 8'hA5) begin
        errors++; $display("FAIL single_data: got %h expected a5", got0[base]);
      end
      lat = gotc0[base] - st;
      checks++;
      if (lat < 152 || lat > 156) begin
        errors++; $display("FAIL single_latency: got %0d expected 154+-2", lat);
      end
    end
    checks++;
    if (vh0 - vb !== 1) begin
      errors++; $display("FAIL single_valid_width: got %0d cycles expected 1", vh0 - vb);
    end
    checks++;
    if ((fe_n0 - fb) + (pe_n0 - pb) + (ov_n0 - ob) !== 0) begin
      errors++; $display("FAIL single_err_pulses: got %0d expected 0", (fe_n0 - fb) + (pe_n0 - pb) + (ov_n0 - ob));
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[3];
    int base, st;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    base = got0.size();
    for (int i = 0; i < 3; i++) send_frame(0, exp_b[i], 1'b0, 1'b0, 1'b1, st);
    wait_cyc(2 * CPB);
    checks++;
    if (got0.size() - base !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d bytes expected 3", got0.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got0[base + i] !== exp_b[i]) begin
          errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, got0[base + i], exp_b[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (gotc0[base + i] - gotc0[base + i - 1] !== 10 * CPB) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", i,
                             gotc0[base + i] - gotc0[base + i - 1], 10 * CPB);
        end
      end
    end
  endtask

  task automatic test_overrun;
    int base, ob, st;
    base = got0.size(); ob = ov_n0;
    rdy0 = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, st);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, st);
    wait_cyc(2 * CPB);
    checks++;
    if ({v0, d0} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL overrun_hold: got v=%b d=%h expected v=1 d=11", v0, d0);
    end
    checks++;
    if (ov_n0 - ob !== 1) begin
      errors++; $display("FAIL overrun_pulses: got %0d expected 1", ov_n0 - ob);
    end
    rdy0 = 1'b1;
    wait_cyc(1);
    checks++;
    if (v0 !== 1'b0) begin
      errors++; $display("FAIL overrun_release: got v=%b expected 0", v0);
    end
    checks++;
    if (got0.size() - base !== 1 || got0[got0.size() - 1] !== 8'h11) begin
      errors++; $display("FAIL overrun_accept: got %0d bytes last %h expected 1 byte 11",
                         got0.size() - base, got0[got0.size() - 1]);
    end
  endtask

  task automatic test_framing;
    int base, fb, st;
    base = got0.size(); fb = fe_n0;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, st);
    rx0 = 1'b0;
    wait_cyc(2 * CPB);
    rx0 = 1'b1;
    wait_cyc(2 * CPB);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, st);
    wait_cyc(2 * CPB);
    checks++;
    if (fe_n0 - fb !== 1) begin
      errors++; $display("FAIL framing_pulses: got %0d expected 1", fe_n0 - fb);
    end
    checks++;
    if (got0.size() - base !== 1 || got0[got0.size() - 1] !== 8'h81) begin
      errors++; $display("FAIL framing_recover: got %0d bytes last %h expected 1 byte 81",
                         got0.size() - base, got0[got0.size() - 1]);
    end
  endtask

  task automatic test_glitch;
    int base, bb, eb;
    base = got0.size(); bb = busy_n0; eb = fe_n0 + pe_n0 + ov_n0;
    rx0 = 1'b0;
    wait_cyc(4);
    rx0 = 1'b1;
    wait_cyc(3 * CPB);
    checks++;
    if ((busy_n0 - bb) < 1 || (busy_n0 - bb) >= CPB) begin
      errors++; $display("FAIL glitch_busy: got %0d busy cycles expected 1..%0d", busy_n0 - bb, CPB - 1);
    end
    checks++;
    if (got0.size() - base !== 0 || v0 !== 1'b0 || busy0 !== 1'b0 || fe_n0 + pe_n0 + ov_n0 !== eb) begin
      errors++; $display("FAIL glitch_outputs: got bytes=%0d v=%b busy=%b errs=%0d expected none",
                         got0.size() - base, v0, busy0, fe_n0 + pe_n0 + ov_n0 - eb);
    end
  endtask

  task automatic test_parity;
    int base, pb, pvb, st;
    base = got1.size(); pb = pe_n1; pvb = pev_n1;
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, st);
    wait_cyc(2 * CPB);
    checks++;
    if (got1.size() - base !== 1 || got1[got1.size() - 1] !== 8'h07) begin
      errors++; $display("FAIL parity_data: got %0d bytes last %h expected 1 byte 07",
                         got1.size() - base, got1[got1.size() - 1]);
    end
    checks++;
    if (pe_n1 - pb !== 1 || pev_n1 - pvb !== 1) begin
      errors++; $display("FAIL parity_pulse: got pulses=%0d with_valid=%0d expected 1 and 1",
                         pe_n1 - pb, pev_n1 - pvb);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp0[$], exp1[$];
    int base0, base1, fb, pb, ob, st, exp_fe, exp_pe;
    logic [7:0] b;
    bit bad_par, good_stop;
    base0 = got0.size(); base1 = got1.size();
    fb = fe_n1; pb = pe_n1; ob = ov_n1; exp_fe = 0; exp_pe = 0;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      exp0.push_back(b);
      send_frame(0, b, 1'b0, 1'b0, 1'b1, st);
      wait_cyc($urandom_range(0, CPB));
    end
    wait_cyc(2 * CPB);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      bad_par = ($urandom_range(0, 1) == 1);
      good_stop = ($urandom_range(0, 3) != 0);
      if (good_stop) begin
        exp1.push_back(b);
        if (bad_par) exp_pe++;
      end else begin
        exp_fe++;
      end
      send_frame(1, b, 1'b1, (^b) ^ bad_par, good_stop, st);
      if (!good_stop) wait_cyc(CPB);
    end
    wait_cyc(2 * CPB);
    checks++;
    if (got0.size() - base0 !== exp0.size()) begin
      errors++; $display("FAIL rand0_count: got %0d expected %0d", got0.size() - base0, exp0.size());
    end else begin
      for (int i = 0; i < exp0.size(); i++) begin
        checks++;
        if (got0[base0 + i] !== exp0[i]) begin
          errors++; $display("FAIL rand0_data%0d: got %h expected %h", i, got0[base0 + i], exp0[i]);
        end
      end
    end
    checks++;
    if (got1.size() - base1 !== exp1.size()) begin
      errors++; $display("FAIL rand1_count: got %0d expected %0d", got1.size() - base1, exp1.size());
    end else begin
      for (int i = 0; i < exp1.size(); i++) begin
        checks++;
        if (got1[base1 + i] !== exp1[i]) begin
          errors++; $display("FAIL rand1_data%0d: got %h expected %h", i, got1[base1 + i], exp1[i]);
        end
      end
    end
    checks++;
    if (fe_n1 - fb !== exp_fe || pe_n1 - pb !== exp_pe || ov_n1 - ob !== 0) begin
      errors++; $display("FAIL rand1_errs: got fe=%0d pe=%0d ov=%0d expected fe=%0d pe=%0d ov=0",
                         fe_n1 - fb, pe_n1 - pb, ov_n1 - ob, exp_fe, exp_pe);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int base, eb, st;
    b = 8'hC3;
    base = got0.size(); eb = fe_n0 + pe_n0 + ov_n0;
    rx0 = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx0 = b[i];
      wait_cyc(CPB);
    end
    rst = 1'b0;
    rx0 = 1'b1;
    wait_cyc(3);
    checks++;
    if ({d0, v0, busy0, fe0, pe0, ov0} !== 13'd0) begin
      errors++; $display("FAIL midreset_outputs: got %b expected all zero", {d0, v0, busy0, fe0, pe0, ov0});
    end
    rst = 1'b1;
    wait_cyc(2 * CPB);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, st);
    wait_cyc(2 * CPB);
    checks++;
    if (got0.size() - base !== 1 || got0[got0.size() - 1] !== 8'h3C) begin
      errors++; $display("FAIL midreset_data: got %0d bytes last %h expected 1 byte 3c",
                         got0.size() - base, got0[got0.size() - 1]);
    end
    checks++;
    if (fe_n0 + pe_n0 + ov_n0 !== eb) begin
      errors++; $display("FAIL midreset_errs: got %0d error pulses expected 0", fe_n0 + pe_n0 + ov_n0 - eb);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_parity();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
